// File: rtl/cp0_regfile_if.sv
// CP0 shared types and the WB <-> CP0 register access interface.
// addr is {rd[4:0], sel[2:0]}; rdata is combinational from CP0 state.
package cp0_pkg;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef struct packed {
    logic        bd;
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic        eret_flush;
    exception_t  exception;
    logic [31:0] pc;
  } ws_to_c0_bus_t;

  typedef struct packed {
    logic ex;
    logic eret;
  } pipeline_flush_t;

endpackage

interface WB_C0_Interface;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport WB (
    output we, addr, wdata,
    input  rdata
  );

  modport C0 (
    input  we, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file and exception controller fed by WB commits.
// Drives flush/redirect and the pending-interrupt flag back to ID.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        ext_int_in,
  input  ws_to_c0_bus_t     ws_to_c0_bus,
  WB_C0_Interface.C0        c0,
  output pipeline_flush_t   c0_flush,
  output logic [31:0]       c0_flush_target,
  output logic              has_int
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [7:2]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;

  logic        ex;
  logic        eret;
  logic        sel_ok;
  logic        wr;
  logic [4:0]  rnum;
  logic [7:0]  ip;
  logic [31:0] status;
  logic [31:0] cause;

  assign ex     = ws_to_c0_bus.exception.ex;
  assign eret   = ws_to_c0_bus.eret_flush;
  assign rnum   = c0.addr[7:3];
  assign sel_ok = c0.addr[2:0] == 3'd0;
  assign wr     = c0.we & sel_ok & ~ex & ~eret;

  assign ip     = {ip_hw_q, ip_sw_q};
  assign status = {9'b0, 1'b1, 6'b0, im_q,
                   6'b0, exl_q, ie_q};
  assign cause  = {bd_q, ti_q, 14'b0, ip,
                   1'b0, exccode_q, 2'b0};

  assign c0_flush.ex     = ex;
  assign c0_flush.eret   = eret & ~ex;
  assign c0_flush_target = ex ? EX_ENTRY : epc_q;
  assign has_int = (|(ip & im_q)) & ie_q & ~exl_q;

  always_comb begin
    c0.rdata = 32'b0;
    if (sel_ok) begin
      unique case (1'b1)
        rnum == CR_BADVADDR: c0.rdata = badvaddr_q;
        rnum == CR_COUNT:    c0.rdata = count_q;
        rnum == CR_COMPARE:  c0.rdata = compare_q;
        rnum == CR_STATUS:   c0.rdata = status;
        rnum == CR_CAUSE:    c0.rdata = cause;
        rnum == CR_EPC:      c0.rdata = epc_q;
        default:             c0.rdata = 32'b0;
      endcase
    end
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    ip_hw_d    = {ext_int_in[5] | ti_q, ext_int_in[4:0]};
    tick_d     = ~tick_q;
    count_d    = count_q + {31'b0, tick_q};
    ti_d       = ti_q | (count_q == compare_q);
    if (ex) begin
      exl_d     = 1'b1;
      exccode_d = ws_to_c0_bus.exception.exccode;
      if (!exl_q) begin
        bd_d  = ws_to_c0_bus.exception.bd;
        epc_d = ws_to_c0_bus.exception.bd
              ? ws_to_c0_bus.pc - 32'd4
              : ws_to_c0_bus.pc;
      end
      if (ws_to_c0_bus.exception.exccode == EXC_ADEL ||
          ws_to_c0_bus.exception.exccode == EXC_ADES)
        badvaddr_d = ws_to_c0_bus.exception.badvaddr;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (wr) begin
      unique case (1'b1)
        rnum == CR_STATUS: begin
          im_d  = c0.wdata[15:8];
          exl_d = c0.wdata[1];
          ie_d  = c0.wdata[0];
        end
        rnum == CR_CAUSE: ip_sw_d = c0.wdata[9:8];
        rnum == CR_EPC:   epc_d = c0.wdata;
        rnum == CR_COUNT: begin
          count_d = c0.wdata;
          tick_d  = 1'b0;
        end
        // A Compare write wins over a same-cycle match
        rnum == CR_COMPARE: begin
          compare_d = c0.wdata;
          ti_d      = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 8'b0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exccode_q  <= 5'b0;
      ip_hw_q    <= 6'b0;
      ip_sw_q    <= 2'b0;
      epc_q      <= 32'b0;
      badvaddr_q <= 32'b0;
      count_q    <= 32'b0;
      compare_q  <= 32'b0;
      tick_q     <= 1'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed steps plus random traffic,
// all compared against a word-level CP0 reference model.
module tb_cp0_regfile;
  import cp0_pkg::*;

  localparam logic [31:0] EXV = 32'hbfc00380;
  localparam logic [7:0] A_ST  = 8'h60;
  localparam logic [7:0] A_CA  = 8'h68;
  localparam logic [7:0] A_EPC = 8'h70;
  localparam logic [7:0] A_BAD = 8'h40;
  localparam logic [7:0] A_CNT = 8'h48;
  localparam logic [7:0] A_CMP = 8'h58;

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      ext;
  ws_to_c0_bus_t   bus;
  pipeline_flush_t fl;
  logic [31:0]     tgt;
  logic            pend;

  WB_C0_Interface cif();

  cp0_regfile #(.EX_ENTRY(EXV)) dut (
    .clk(clk),
    .reset(reset),
    .ext_int_in(ext),
    .ws_to_c0_bus(bus),
    .c0(cif.C0),
    .c0_flush(fl),
    .c0_flush_target(tgt),
    .has_int(pend)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_status, m_cause, m_epc, m_bad;
  logic [31:0] m_count, m_cmp;
  logic        m_tick;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a[2:0] != 3'd0) return 32'h0;
    case (a[7:3])
      CR_STATUS:   return m_status;
      CR_CAUSE:    return m_cause;
      CR_EPC:      return m_epc;
      CR_BADVADDR: return m_bad;
      CR_COUNT:    return m_count;
      CR_COMPARE:  return m_cmp;
      default:     return 32'h0;
    endcase
  endfunction

  function automatic logic m_hint();
    return (|(m_cause[15:8] & m_status[15:8]))
           & m_status[0] & ~m_status[1];
  endfunction

  // Apply one clock edge of CP0 behaviour to the model
  task automatic mstep();
    logic [31:0] s, c, e, b, cn, cm;
    logic t, wr;
    if (reset) begin
      m_status = 32'h00400000;
      m_cause = 0; m_epc = 0; m_bad = 0;
      m_count = 0; m_cmp = 0; m_tick = 0;
      return;
    end
    s = m_status; c = m_cause; e = m_epc; b = m_bad;
    cn = m_count; cm = m_cmp;
    c[15:10] = {ext[5] | m_cause[30], ext[4:0]};
    if (m_tick) cn = m_count + 1;
    t = ~m_tick;
    if (m_count == m_cmp) c[30] = 1'b1;
    wr = cif.we && cif.addr[2:0] == 3'd0
         && !bus.exception.ex && !bus.eret_flush;
    if (bus.exception.ex) begin
      s[1] = 1'b1;
      c[6:2] = bus.exception.exccode;
      if (!m_status[1]) begin
        c[31] = bus.exception.bd;
        e = bus.exception.bd ? bus.pc - 4 : bus.pc;
      end
      if (bus.exception.exccode == EXC_ADEL ||
          bus.exception.exccode == EXC_ADES)
        b = bus.exception.badvaddr;
    end else if (bus.eret_flush) begin
      s[1] = 1'b0;
    end else if (wr) begin
      case (cif.addr[7:3])
        CR_STATUS: s = 32'h00400000 | (cif.wdata & 32'h0000ff03);
        CR_CAUSE:  c[9:8] = cif.wdata[9:8];
        CR_EPC:    e = cif.wdata;
        CR_COUNT:  begin cn = cif.wdata; t = 1'b0; end
        CR_COMPARE: begin cm = cif.wdata; c[30] = 1'b0; end
        default: ;
      endcase
    end
    m_status = s; m_cause = c; m_epc = e; m_bad = b;
    m_count = cn; m_cmp = cm; m_tick = t;
  endtask

  task automatic cyc();
    #1;
    chk("rdata", cif.rdata, m_read(cif.addr));
    chk("has_int", {31'b0, pend}, {31'b0, m_hint()});
    chk("flush_ex", {31'b0, fl.ex}, {31'b0, bus.exception.ex});
    chk("flush_eret", {31'b0, fl.eret},
        {31'b0, bus.eret_flush & ~bus.exception.ex});
    chk("flush_target", tgt,
        bus.exception.ex ? EXV : m_epc);
    @(posedge clk);
    mstep();
    @(negedge clk);
  endtask

  task automatic idle();
    cif.we = 1'b0;
    cif.wdata = '0;
    bus = '0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    cif.we = 1'b1; cif.addr = a; cif.wdata = d;
    cyc();
    idle();
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [31:0] exp);
    cif.addr = a;
    #1;
    chk(tag, cif.rdata, exp);
  endtask

  task automatic raise(input logic [4:0] code, input logic bdv,
                       input logic [31:0] pcv, input logic [31:0] bva);
    bus.exception.ex = 1'b1;
    bus.exception.exccode = code;
    bus.exception.bd = bdv;
    bus.exception.badvaddr = bva;
    bus.pc = pcv;
  endtask

  initial begin
    logic [7:0]  ra [8];
    logic [31:0] re [8];
    logic [4:0]  codes [4];
    int n;
    ra = '{A_ST, A_CA, A_EPC, A_BAD, A_CNT, A_CMP, 8'h18, 8'h61};
    re = '{32'h00400000, 0, 0, 0, 0, 0, 0, 0};
    codes = '{EXC_ADEL, EXC_ADES, EXC_SYS, EXC_OV};
    reset = 1'b1; ext = '0; cif.addr = '0;
    idle();
    @(posedge clk); mstep();
    @(posedge clk); mstep();
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_rd%0d", i), ra[i], re[i]);
    cyc();
    reset = 1'b0;

    mtc0(A_CMP, 32'hffff0000);

    raise(EXC_ADEL, 1'b1, 32'hbfc00104, 32'h3);
    #1;
    chk("adel_flush_ex", {31'b0, fl.ex}, 32'd1);
    chk("adel_target", tgt, 32'hbfc00380);
    cyc(); idle();
    rd("adel_epc", A_EPC, 32'hbfc00100);
    rd("adel_cause", A_CA, 32'h80000010);
    rd("adel_bad", A_BAD, 32'h3);
    rd("adel_status", A_ST, 32'h00400002);
    cyc();

    raise(EXC_SYS, 1'b0, 32'h00001000, 32'h0);
    cyc(); idle();
    rd("sys_epc", A_EPC, 32'hbfc00100);
    rd("sys_cause", A_CA, 32'h80000020);
    cyc();

    mtc0(A_EPC, 32'hbfc00200);
    bus.eret_flush = 1'b1;
    #1;
    chk("eret_flush", {31'b0, fl.eret}, 32'd1);
    chk("eret_target", tgt, 32'hbfc00200);
    cyc(); idle();
    rd("eret_status", A_ST, 32'h00400000);
    cyc();

    bus.eret_flush = 1'b1;
    raise(EXC_OV, 1'b0, 32'h80000000, 32'h0);
    #1;
    chk("eret_ex_eret", {31'b0, fl.eret}, 32'd0);
    chk("eret_ex_ex", {31'b0, fl.ex}, 32'd1);
    cyc(); idle();
    bus.eret_flush = 1'b1;
    cyc(); idle();

    mtc0(A_ST, 32'h00408001);
    mtc0(A_CNT, 32'd5);
    mtc0(A_CMP, 32'd7);
    cif.addr = A_CA;
    n = 0;
    while (!cif.rdata[30] && n < 12) begin cyc(); n++; end
    chk("ti_latency", {31'b0, n >= 4 && n <= 5}, 32'd1);
    cyc();
    chk("timer_has_int", {31'b0, pend}, 32'd1);
    mtc0(A_CMP, 32'hffffff00);
    cyc();
    chk("ti_clear_has_int", {31'b0, pend}, 32'd0);
    rd("ti_clear_cause", A_CA, 32'h00000030);

    mtc0(A_ST, 32'h00400101);
    mtc0(A_CA, 32'h00000100);
    #1;
    chk("sw_int", {31'b0, pend}, 32'd1);
    mtc0(A_ST, 32'h00400103);
    #1;
    chk("sw_int_exl", {31'b0, pend}, 32'd0);

    mtc0(A_ST, 32'h00400101);
    cif.we = 1'b1; cif.addr = A_ST; cif.wdata = 32'h0040ff00;
    raise(EXC_OV, 1'b0, 32'h00002000, 32'h0);
    cyc(); idle();
    rd("ex_beats_mtc0", A_ST, 32'h00400103);
    cyc();

    for (int i = 0; i < 400; i++) begin
      idle();
      reset = ($urandom_range(0, 149) == 0);
      ext = 6'($urandom);
      if ($urandom_range(0, 15) == 0)
        raise(codes[$urandom_range(0, 3)], 1'($urandom),
              $urandom, $urandom);
      if ($urandom_range(0, 15) == 0) bus.eret_flush = 1'b1;
      cif.addr = ra[$urandom_range(0, 7)];
      if ($urandom_range(0, 2) == 0) begin
        cif.we = 1'b1;
        cif.wdata = (cif.addr == A_CNT || cif.addr == A_CMP)
                  ? 32'($urandom_range(0, 40)) : $urandom;
      end
      cyc();
    end
    reset = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
